// File: rtl/crypto_batch_sequencer_pkg.sv
// Shared types and encodings for the crypto batch sequencer.
package crypto_batch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_FINISH
  } state_t;

  localparam logic [1:0] MODE_REPEAT = 2'd0;
  localparam logic [1:0] MODE_CHAIN  = 2'd1;
  localparam logic [1:0] MODE_CTR    = 2'd2;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ABORT   = 2'd2;

endpackage

// File: rtl/crypto_batch_sequencer_pt_next_gen.sv
// Next-block plaintext selection: repeat, chain (previous ct) or base + count.
module crypto_batch_sequencer_pt_next_gen
  import crypto_batch_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic [1:0]       mode,
  input  logic [127:0]     base_pt,
  input  logic [127:0]     cur_pt,
  input  logic [127:0]     ct,
  input  logic [CNT_W-1:0] count,
  output logic [127:0]     next_pt
);

  always_comb begin
    next_pt = cur_pt;
    case (mode)
      MODE_CHAIN: next_pt = ct;
      MODE_CTR:   next_pt = base_pt + 128'(count);
      default:    next_pt = cur_pt;
    endcase
  end

endmodule

// File: rtl/crypto_batch_sequencer.sv
// Runs a batch of encryptions through the crypto core and drives the capture trigger.
module crypto_batch_sequencer
  import crypto_batch_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned TIMEOUT         = 1024,
  parameter int unsigned TRIG_FIRST_ONLY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] num_blocks,
  input  logic [127:0]     key_in,
  input  logic [127:0]     pt_in,
  output logic [127:0]     core_key,
  output logic [127:0]     core_pt,
  output logic             core_load,
  input  logic             core_busy,
  input  logic [127:0]     core_ct,
  output logic [127:0]     ct_out,
  output logic [CNT_W-1:0] blocks_done,
  output logic [31:0]      cycle_count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err,
  output logic             trigger
);

  localparam int unsigned      TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic             TRIG_ALL = (TRIG_FIRST_ONLY == 0);

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [127:0]     base_pt;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] cnt_nxt;
  logic [127:0]     pt_nxt;
  logic             timer_expired;

  assign cnt_nxt       = blocks_done + CNT_W'(1);
  assign timer_expired = (timer >= TMR_LAST);

  crypto_batch_sequencer_pt_next_gen #(
    .CNT_W (CNT_W)
  ) u_pt_next_gen (
    .mode    (mode_q),
    .base_pt (base_pt),
    .cur_pt  (core_pt),
    .ct      (core_ct),
    .count   (cnt_nxt),
    .next_pt (pt_nxt)
  );

  // Trigger is written alongside each state change so it lines up with the
  // state it qualifies rather than lagging it by a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      timer       <= '0;
      base_pt     <= '0;
      mode_q      <= MODE_REPEAT;
      target      <= '0;
      core_key    <= '0;
      core_pt     <= '0;
      core_load   <= 1'b0;
      ct_out      <= '0;
      blocks_done <= '0;
      cycle_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= ERR_OK;
      trigger     <= 1'b0;
    end else begin
      core_load <= 1'b0;
      done      <= 1'b0;
      if (state != ST_IDLE && cycle_count != '1) begin
        cycle_count <= cycle_count + 32'd1;
      end

      if (state != ST_IDLE && abort) begin
        state   <= ST_IDLE;
        busy    <= 1'b0;
        err     <= ERR_ABORT;
        trigger <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              core_key    <= key_in;
              core_pt     <= pt_in;
              base_pt     <= pt_in;
              mode_q      <= mode;
              target      <= num_blocks;
              blocks_done <= '0;
              cycle_count <= '0;
              err         <= ERR_OK;
              timer       <= '0;
              busy        <= 1'b1;
              if (num_blocks == '0) begin
                state   <= ST_FINISH;
                done    <= 1'b1;
                trigger <= 1'b0;
              end else begin
                state     <= ST_LOAD;
                core_load <= 1'b1;
                trigger   <= 1'b1;
              end
            end
          end

          ST_LOAD: begin
            timer <= '0;
            state <= ST_WAIT_HI;
          end

          ST_WAIT_HI: begin
            timer <= timer + TMR_W'(1);
            if (core_busy) begin
              state <= ST_WAIT_LO;
            end else if (timer_expired) begin
              state   <= ST_FINISH;
              done    <= 1'b1;
              err     <= ERR_TIMEOUT;
              trigger <= 1'b0;
            end
          end

          ST_WAIT_LO: begin
            timer <= timer + TMR_W'(1);
            if (!core_busy) begin
              ct_out      <= core_ct;
              blocks_done <= cnt_nxt;
              core_pt     <= pt_nxt;
              if (cnt_nxt == target) begin
                state   <= ST_FINISH;
                done    <= 1'b1;
                trigger <= 1'b0;
              end else begin
                state     <= ST_LOAD;
                core_load <= 1'b1;
                trigger   <= TRIG_ALL;
              end
            end else if (timer_expired) begin
              state   <= ST_FINISH;
              done    <= 1'b1;
              err     <= ERR_TIMEOUT;
              trigger <= 1'b0;
            end
          end

          ST_FINISH: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end

          default: begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            trigger <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/crypto_batch_sequencer.md
# crypto_batch_sequencer

Sequences repeated encryptions through the 128-bit crypto core (load/busy handshake) for trace-capture batches. It sits between the register block and the core, on the crypto clock. It latches key and plaintext on a start pulse, then issues `num_blocks` loads in repeat, chain or counter mode. It drives the capture trigger and reports the final ciphertext, block count, elapsed cycles and error status.

## Interface
- `CNT_W`, 16: width of block count.
- `TIMEOUT`, 1024: maximum cycles per block from load to busy falling.
- `TRIG_FIRST_ONLY`, 0: 1 = trigger spans first block only; 0 = whole batch.
- `clk`  in  1  crypto clock; one clock domain only.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle batch start request.
- `abort`  in  1  cancel the running batch.
- `mode`  in  2  0 repeat, 1 chain, 2 counter, 3 treated as repeat.
- `num_blocks`  in  CNT_W  number of encryptions.
- `key_in`, `pt_in`  in  128 each  key and base plaintext, sampled on accepted start.
- `core_key`  out  128  latched key, stable for whole batch.
- `core_pt`  out  128  plaintext for current block.
- `core_load`  out  1  one-cycle load pulse.
- `core_busy`  in  1  core busy.
- `core_ct`  in  128  core result, valid when busy falls.
- `ct_out`  out  128  last captured ciphertext.
- `blocks_done`  out  CNT_W  completed blocks this batch.
- `cycle_count`  out  32  cycles spent out of IDLE; saturates at 0xFFFF_FFFF.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when a batch completes or times out.
- `err`  out  2  status: 0 ok, 1 timeout, 2 abort. Sticky until the next accepted start.
- `trigger`  out  1  capture trigger.

## Operation
- States: IDLE, LOAD, WAIT_HI, WAIT_LO, FINISH.
- **IDLE.** `start` is accepted only in IDLE and is ignored otherwise. On acceptance:
  - latch key and pt; clear `blocks_done`, `cycle_count`, `err` and the block timer.
  - If `num_blocks`==0, go to FINISH; otherwise go to LOAD.
- **LOAD.** `core_load`=1 for exactly one cycle with `core_pt` valid; go to WAIT_HI.
- **WAIT_HI.** Wait for `core_busy`=1, then go to WAIT_LO.
- **WAIT_LO.** Wait for `core_busy`=0. On that cycle:
  - capture `core_ct` into `ct_out`;
  - increment `blocks_done`;
  - update the plaintext for the next block per mode;
  - if the new count equals `num_blocks`, go to FINISH; otherwise go to LOAD.
- **Plaintext update per mode.**
  - Repeat: unchanged.
  - Chain: next pt = captured ct.
  - Counter: next pt = base pt + `blocks_done`, mod 2^128 (wraps, no carry out).
- **FINISH.** `done`=1 for one cycle; return to IDLE.
- **Timeout.** A block timer counts cycles spent in WAIT_HI plus WAIT_LO and is cleared in LOAD. When it reaches `TIMEOUT`: `err`=1, go to FINISH. `ct_out` and `blocks_done` keep their last good values.
- **Abort.** `abort` in any non-IDLE state: next state IDLE, `err`=2, no `done` pulse.
  - If `abort` and `start` arrive together in IDLE, `start` wins.
- **Trigger.**
  - With `TRIG_FIRST_ONLY`=0: `trigger` = registered (state in LOAD/WAIT_HI/WAIT_LO).
  - With `TRIG_FIRST_ONLY`=1: same condition, additionally gated with `blocks_done`==0.

## Timing
- **Reset values.** All outputs 0; state IDLE; `core_key`/`core_pt` 0.
- **Start to load.** Start accepted at edge N → LOAD during cycle N+1 → `core_load` high in cycle N+1.
- **Per-block overhead.** 1 LOAD cycle + 1 capture cycle on top of core busy time. The next `core_load` comes 1 cycle after busy falls.
- **Done.** `done` asserts the cycle after the last capture; `busy` falls the cycle after `done`.
- **Outputs.** All are registered; no combinational path from inputs to outputs.
- **`core_key`.** Must not change while `busy`=1.
- **Reset mid-batch.** Immediate return to IDLE, all outputs cleared. The core is not reset by this block.

## Structure
- Shared package holds:
  - the state enum;
  - mode encodings (MODE_REPEAT/CHAIN/CTR);
  - err codes (ERR_OK/TIMEOUT/ABORT).
- Optional sub-module `pt_next_gen`: purely combinational next-plaintext mux plus 128-bit adder. Everything else stays in one module.

## Test plan
- **Single block, real core.** FIPS-197 key 000102…0f, pt 00112233…eeff, mode 0, `num_blocks`=1 → `ct_out`=69c4e0d86a7b0430d8cdb78070b4c55a, `blocks_done`=1, one `done`, `err`=0.
- **Counter wrap.** Behavioural core with busy for 10 cycles, mode 2, pt=FF…FF, `num_blocks`=3 → loaded pts FF…FF, 00…00, 00…01. `cycle_count`=3×(1+1+10)+1 = 37.
- **Chain mode.** Mode 1, `num_blocks`=2 → second `core_pt` equals first captured ct. `TRIG_FIRST_ONLY`=1 → trigger drops after first capture.
- **Timeout.** Core never raises busy, `TIMEOUT`=16 → `done` 17 cycles after load, `err`=1, `blocks_done`=0.
- **Abort and stray start.** `abort` mid-WAIT_LO → IDLE next cycle, `err`=2, no `done`. `start` while busy → ignored, count unchanged.
- **Edge cases.** `num_blocks`=0 → `done` one cycle after start, no `core_load`. `rst_n` low mid-batch → all outputs 0 asynchronously.
